// File: rtl/led_pkg.sv
// Shared constants, pixel type and receive FSM states for the LED strand blocks.
// Timing values assume a 100 MHz clock.
package led_pkg;

    localparam int T0H_CYCLES = 40;
    localparam int T1H_CYCLES = 80;
    localparam int BIT_PERIOD_CYCLES = 125;
    localparam int LATCH_CYCLES_100M = 5000;

    localparam int DEF_NUM_LEDS = 2;
    localparam int DEF_COLOR_WIDTH = 8;
    localparam int DEF_BIT_THRESHOLD = 60;
    localparam int DEF_MIN_HIGH = 20;
    localparam int DEF_MAX_HIGH = 110;

    typedef struct packed {
        logic [DEF_COLOR_WIDTH-1:0] red;
        logic [DEF_COLOR_WIDTH-1:0] green;
        logic [DEF_COLOR_WIDTH-1:0] blue;
    } rgb_t;

    typedef enum logic [1:0] {
        WAIT_LATCH,
        IDLE,
        HIGH,
        LOW
    } strand_state_t;

endpackage

// File: rtl/strand_bit_slicer.sv
// Pulse-width bit slicer: optional input sync (STRAND_DECODER_SYNC_EN),
// edge detect, high/low counters and the receive FSM.
module strand_bit_slicer
    import led_pkg::*;
#(
    parameter int BIT_THRESHOLD_CYCLES = DEF_BIT_THRESHOLD,
    parameter int MIN_HIGH_CYCLES = DEF_MIN_HIGH,
    parameter int MAX_HIGH_CYCLES = DEF_MAX_HIGH,
    parameter int LATCH_CYCLES = LATCH_CYCLES_100M
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic strand_in,
    output logic bit_valid,
    output logic bit_val,
    output logic latch,
    output logic err
);

    localparam int HW = $clog2(MAX_HIGH_CYCLES + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam logic [HW-1:0] MinW = HW'(MIN_HIGH_CYCLES);
    localparam logic [HW-1:0] ThrW = HW'(BIT_THRESHOLD_CYCLES);
    localparam logic [HW-1:0] MaxW = HW'(MAX_HIGH_CYCLES);
    localparam logic [LW-1:0] LatchW = LW'(LATCH_CYCLES);
    localparam logic [LW-1:0] OneLow = LW'(1);

    logic s;
    logic s_q;
    logic rise;
    logic fall;

`ifdef STRAND_DECODER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], strand_in};
        end
    end

    assign s = sync_q[1];
`else
    assign s = strand_in;
`endif

    assign rise = s & ~s_q;
    assign fall = ~s & s_q;

    strand_state_t state;
    strand_state_t state_nxt;
    logic [HW-1:0] high_cnt;
    logic [HW-1:0] high_nxt;
    logic [HW-1:0] high_inc;
    logic [LW-1:0] low_cnt;
    logic [LW-1:0] low_nxt;
    logic [LW-1:0] low_inc;

    // Both counters saturate rather than wrap.
    assign high_inc = (high_cnt >= MaxW) ? high_cnt : high_cnt + 1'b1;
    assign low_inc = (low_cnt >= LatchW) ? low_cnt : low_cnt + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= WAIT_LATCH;
            high_cnt <= '0;
            low_cnt <= '0;
            s_q <= 1'b0;
        end else begin
            state <= state_nxt;
            high_cnt <= high_nxt;
            low_cnt <= low_nxt;
            s_q <= s;
        end
    end

    always_comb begin
        state_nxt = state;
        high_nxt = high_cnt;
        low_nxt = low_cnt;
        bit_valid = 1'b0;
        bit_val = 1'b0;
        latch = 1'b0;
        err = 1'b0;
        unique case (state)
            WAIT_LATCH: begin
                if (s) begin
                    low_nxt = '0;
                end else if (low_inc >= LatchW) begin
                    low_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    low_nxt = low_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    high_nxt = '0;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                // The fall cycle is the first low cycle of the gap.
                if (fall) begin
                    low_nxt = OneLow;
                    if (high_inc < MinW) begin
                        err = 1'b1;
                        state_nxt = WAIT_LATCH;
                    end else begin
                        bit_valid = 1'b1;
                        bit_val = (high_inc >= ThrW);
                        state_nxt = LOW;
                    end
                end else begin
                    high_nxt = high_inc;
                    if (high_inc >= MaxW) begin
                        err = 1'b1;
                        low_nxt = '0;
                        state_nxt = WAIT_LATCH;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    high_nxt = '0;
                    state_nxt = HIGH;
                end else if (low_inc >= LatchW) begin
                    latch = 1'b1;
                    low_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    low_nxt = low_inc;
                end
            end
            default: state_nxt = WAIT_LATCH;
        endcase
    end

endmodule

// File: rtl/strand_decoder.sv
// NZR LED strand receiver: GRB pixel assembly, indexing and frame accounting.
// Define STRAND_DECODER_SYNC_EN when strand_in comes from a pin.
module strand_decoder
    import led_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
    parameter int BIT_THRESHOLD_CYCLES = DEF_BIT_THRESHOLD,
    parameter int MIN_HIGH_CYCLES = DEF_MIN_HIGH,
    parameter int MAX_HIGH_CYCLES = DEF_MAX_HIGH,
    parameter int LATCH_CYCLES = LATCH_CYCLES_100M,
    localparam int CounterWidth = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    localparam int PixCountWidth = $clog2(NUM_LEDS + 1)
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic strand_in,
    output logic [CounterWidth-1:0] led_index_out,
    output logic [COLOR_WIDTH-1:0] red_out,
    output logic [COLOR_WIDTH-1:0] green_out,
    output logic [COLOR_WIDTH-1:0] blue_out,
    output logic color_valid,
    output logic frame_done,
    output logic [PixCountWidth-1:0] pixel_count_out,
    output logic overflow_out,
    output logic error_out
);

    localparam int PixelBits = 3 * COLOR_WIDTH;
    localparam int BitCntWidth = $clog2(PixelBits + 1);
    localparam logic [BitCntWidth-1:0] LastBit = BitCntWidth'(PixelBits - 1);
    localparam logic [PixCountWidth-1:0] NumLedsW = PixCountWidth'(NUM_LEDS);

    logic bit_valid;
    logic bit_val;
    logic latch;
    logic err;

    strand_bit_slicer #(
        .BIT_THRESHOLD_CYCLES(BIT_THRESHOLD_CYCLES),
        .MIN_HIGH_CYCLES(MIN_HIGH_CYCLES),
        .MAX_HIGH_CYCLES(MAX_HIGH_CYCLES),
        .LATCH_CYCLES(LATCH_CYCLES)
    ) u_slicer (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .strand_in(strand_in),
        .bit_valid(bit_valid),
        .bit_val(bit_val),
        .latch(latch),
        .err(err)
    );

    logic [PixelBits-1:0] pixel_q;
    logic [PixelBits-1:0] pixel_shift;
    logic [BitCntWidth-1:0] bit_cnt;
    logic [PixCountWidth-1:0] pix_num;
    logic ovf_q;
    logic pixel_full;
    logic room;

    // Wire order is G, R, B, MSB first.
    assign pixel_shift = {pixel_q[PixelBits-2:0], bit_val};
    assign pixel_full = (bit_cnt == LastBit);
    assign room = (pix_num < NumLedsW);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            led_index_out <= '0;
            red_out <= '0;
            green_out <= '0;
            blue_out <= '0;
            color_valid <= 1'b0;
            frame_done <= 1'b0;
            pixel_count_out <= '0;
            overflow_out <= 1'b0;
            error_out <= 1'b0;
            pixel_q <= '0;
            bit_cnt <= '0;
            pix_num <= '0;
            ovf_q <= 1'b0;
        end else begin
            color_valid <= 1'b0;
            frame_done <= 1'b0;
            overflow_out <= 1'b0;
            error_out <= 1'b0;
            unique case (1'b1)
                err: begin
                    // A broken frame is abandoned; the slicer waits for a latch.
                    error_out <= 1'b1;
                    bit_cnt <= '0;
                    pix_num <= '0;
                    ovf_q <= 1'b0;
                end
                latch: begin
                    frame_done <= 1'b1;
                    pixel_count_out <= pix_num;
                    overflow_out <= ovf_q;
                    error_out <= (bit_cnt != '0);
                    bit_cnt <= '0;
                    pix_num <= '0;
                    ovf_q <= 1'b0;
                end
                bit_valid: begin
                    pixel_q <= pixel_shift;
                    if (pixel_full) begin
                        bit_cnt <= '0;
                        if (room) begin
                            color_valid <= 1'b1;
                            green_out <= pixel_shift[PixelBits-1 -: COLOR_WIDTH];
                            red_out <= pixel_shift[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
                            blue_out <= pixel_shift[COLOR_WIDTH-1:0];
                            led_index_out <= pix_num[CounterWidth-1:0];
                            pix_num <= pix_num + 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_strand_decoder.sv
// Directed bench for strand_decoder with a strobe scoreboard.
module tb_strand_decoder;
    import led_pkg::*;

`ifdef STRAND_DECODER_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    localparam int LATCH = LATCH_CYCLES_100M;

    localparam rgb_t P0 = '{red: 8'h34, green: 8'h12, blue: 8'h56};
    localparam rgb_t P1 = '{red: 8'hA5, green: 8'h0F, blue: 8'hC3};
    localparam rgb_t P2 = '{red: 8'h01, green: 8'hFE, blue: 8'h80};
    localparam rgb_t P3 = '{red: 8'h7E, green: 8'h99, blue: 8'h3C};

    logic clk = 1'b0;
    logic rst;
    logic strand;
    logic [0:0] idx;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic cv;
    logic fd;
    logic [1:0] cnt;
    logic ovf;
    logic err;

    always #5 clk = ~clk;

    strand_decoder dut (
        .clk_in(clk),
        .rst_in(rst),
        .strand_in(strand),
        .led_index_out(idx),
        .red_out(red),
        .green_out(green),
        .blue_out(blue),
        .color_valid(cv),
        .frame_done(fd),
        .pixel_count_out(cnt),
        .overflow_out(ovf),
        .error_out(err)
    );

    typedef struct {
        int idx;
        rgb_t c;
        int cyc;
    } px_t;

    typedef struct {
        int count;
        int ovf;
        int err;
        int cyc;
    } fr_t;

    px_t pxq[$];
    fr_t frq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_seen = 0;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        strand = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        int hi;
        hi = b ? T1H_CYCLES : T0H_CYCLES;
        strand = 1'b1;
        repeat (hi) tick();
        strand = 1'b0;
        fall_cyc = cyc;
        repeat (BIT_PERIOD_CYCLES - hi) tick();
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[23-i]);
    endtask

    task automatic send_pixel(input rgb_t c);
        send_bits({c.green, c.red, c.blue}, 24);
    endtask

    // Called just before send_pixel: the strobe lands L+1 after the last fall.
    task automatic expect_pixel(input rgb_t c, input int i);
        px_t e;
        int hi;
        hi = c.blue[0] ? T1H_CYCLES : T0H_CYCLES;
        e.idx = i;
        e.c = c;
        e.cyc = cyc + 23 * BIT_PERIOD_CYCLES + hi + L + 1;
        pxq.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pxq.size() != 0 || frq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check("drain_px", 32'(pxq.size()), 0);
        check("drain_fr", 32'(frq.size()), 0);
    endtask

    task automatic end_frame(input int count, input int o, input int e);
        fr_t f;
        f.count = count;
        f.ovf = o;
        f.err = e;
        f.cyc = fall_cyc + L + LATCH;
        frq.push_back(f);
        idle(LATCH + 10);
        drain();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_idx"}, 32'(idx), 0);
        check({tag, "_rgb"}, {8'h0, red, green, blue}, 0);
        check({tag, "_strobes"}, {28'h0, cv, fd, ovf, err}, 0);
        check({tag, "_cnt"}, 32'(cnt), 0);
    endtask

    always @(negedge clk) begin : mon
        px_t e;
        fr_t f;
        if (cv) begin
            check("px_expected", 32'(pxq.size() != 0), 1);
            if (pxq.size() != 0) begin
                e = pxq.pop_front();
                check("px_idx", 32'(idx), 32'(e.idx));
                check("px_red", 32'(red), 32'(e.c.red));
                check("px_green", 32'(green), 32'(e.c.green));
                check("px_blue", 32'(blue), 32'(e.c.blue));
                check("px_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (fd) begin
            check("fr_expected", 32'(frq.size() != 0), 1);
            if (frq.size() != 0) begin
                f = frq.pop_front();
                check("fr_count", 32'(cnt), 32'(f.count));
                check("fr_ovf", 32'(ovf), 32'(f.ovf));
                check("fr_err", 32'(err), 32'(f.err));
                check("fr_cycle", 32'(cyc), 32'(f.cyc));
            end
        end else if (err) begin
            err_seen++;
        end
    end

    initial begin
        rst = 1'b1;
        strand = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        idle(LATCH + 10);

        expect_pixel(P0, 0);
        send_pixel(P0);
        end_frame(1, 0, 0);

        expect_pixel(P1, 0);
        send_pixel(P1);
        expect_pixel(P2, 1);
        send_pixel(P2);
        end_frame(2, 0, 0);

        // 10-cycle glitch mid-pixel; the rest of the pixel must be ignored.
        send_bits(24'hA5C3F0, 6);
        strand = 1'b1;
        repeat (10) tick();
        strand = 1'b0;
        repeat (115) tick();
        send_bits(24'hFFFFFF, 5);
        idle(LATCH + 10);
        check("glitch_err", 32'(err_seen), 1);
        expect_pixel(P3, 0);
        send_pixel(P3);
        end_frame(1, 0, 0);

        send_bits(24'h5A5A5A, 12);
        end_frame(0, 0, 1);
        check("partial_err_cnt", 32'(err_seen), 1);

        expect_pixel(P0, 0);
        send_pixel(P0);
        expect_pixel(P1, 1);
        send_pixel(P1);
        send_pixel(P2);
        end_frame(2, 1, 0);

        send_bits(24'h3C3C3C, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("midreset");
        send_pixel(P3);
        idle(LATCH + 10);
        drain();
        expect_pixel(P2, 0);
        send_pixel(P2);
        end_frame(1, 0, 0);
        check("final_err_cnt", 32'(err_seen), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
